// File: rtl/pio_mailbox_bridge.sv
// pio_mailbox_bridge
//   Command/result mailbox between the HPS PIO pair and N_CH coprocessor
//   channels. The HPS flips a request toggle in hps_cmd to issue one command:
//   either a dispatch to a channel (toggle/valid/ready handshake) or a pop of
//   the show-ahead result FIFO. Channels push results into the FIFO through a
//   round-robin arbiter. hps_status reflects the ack toggle, sticky error and
//   the FIFO head.
//
// Ports
//   clk_clk      single clock, rising edge
//   reset_reset  synchronous active-high reset
//   hps_cmd      {req_tog, op, clr_err, channel[CH_W], payload[PAY_W]}
//   hps_status   {ack_tog, head_valid, err, head_ch[CH_W], head_payload[PAY_W]}
//   cp_valid     one-hot command valid per channel
//   cp_payload   command payload shared by all channels
//   cp_ready     per-channel command ready
//   res_valid    per-channel result valid
//   res_data     result payloads, channel k at [k*PAY_W +: PAY_W]
//   res_ready    per-channel result accept
//
// Build option
//   PIO_BRIDGE_TIMEOUT_EN  when defined, a dispatch that sees no cp_ready
//                          within TIMEOUT_CYC cycles is dropped and sets err.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RESYNC   | first cycle after reset, adopt current req toggle as ack
// IDLE     | wait for req toggle != ack, then pop or start a dispatch
// DISPATCH | hold cp_valid/cp_payload until the selected channel is ready
// ACK      | return the latched toggle on hps_status, back to IDLE

module pio_mailbox_bridge #(
    parameter int WORD_W      = 32,
    parameter int CH_W        = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1024,
    localparam int PAY_W      = WORD_W - 3 - CH_W,
    localparam int N_CH       = 2 ** CH_W
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [WORD_W-1:0]     hps_cmd,
    output logic [WORD_W-1:0]     hps_status,
    output logic [N_CH-1:0]       cp_valid,
    output logic [PAY_W-1:0]      cp_payload,
    input  logic [N_CH-1:0]       cp_ready,
    input  logic [N_CH-1:0]       res_valid,
    input  logic [N_CH*PAY_W-1:0] res_data,
    output logic [N_CH-1:0]       res_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CH_W + PAY_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_DISPATCH,
        ST_ACK
    } state_t;

    // Command register and field views
    logic [WORD_W-1:0] cmd_q;
    logic              cmd_tog;
    logic              cmd_op;
    logic              cmd_clr;
    logic [CH_W-1:0]   cmd_ch;
    logic [PAY_W-1:0]  cmd_pay;
    logic [N_CH-1:0]   cmd_onehot;

    assign cmd_tog = cmd_q[WORD_W-1];
    assign cmd_op  = cmd_q[WORD_W-2];
    assign cmd_clr = cmd_q[WORD_W-3];
    assign cmd_ch  = cmd_q[WORD_W-4 -: CH_W];
    assign cmd_pay = cmd_q[PAY_W-1:0];

    always_comb begin
        cmd_onehot         = '0;
        cmd_onehot[cmd_ch] = 1'b1;
    end

    // Not reset on purpose: RESYNC must see the toggle the HPS is already
    // presenting when reset releases, so a stale toggle never fires.
    always_ff @(posedge clk_clk) begin
        cmd_q <= hps_cmd;
    end

    // FSM registers
    state_t            state_q;
    logic              ack_q;
    logic              err_q;
    logic              lat_tog_q;
    logic [CH_W-1:0]   lat_ch_q;
    logic [N_CH-1:0]   cp_valid_q;
    logic [PAY_W-1:0]  cp_payload_q;

    // FIFO registers
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              head_valid_q, head_valid_d;
    logic [ENT_W-1:0]  head_q, head_d;

    logic              cmd_new;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    assign cmd_new    = (state_q == ST_IDLE) && (cmd_tog != ack_q);
    assign fifo_empty = (count_q == '0);
    assign fifo_pop   = cmd_new && cmd_op && !fifo_empty;

    // Round-robin arbiter: search starts at rr_q and wraps over CH_W bits.
    logic [PAY_W-1:0]  res_slice [N_CH];
    logic              grant_found;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   arb_idx;

    for (genvar k = 0; k < N_CH; k++) begin : g_slice
        assign res_slice[k] = res_data[k*PAY_W +: PAY_W];
    end

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        arb_idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            arb_idx = rr_q + CH_W'(i);
            if (!grant_found && res_valid[arb_idx]) begin
                grant_found = 1'b1;
                grant_ch    = arb_idx;
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop does not
    // open a slot for a push.
    assign fifo_push = grant_found && (count_q < DEPTH_C);

    always_comb begin
        res_ready = '0;
        if (fifo_push && !reset_reset) begin
            res_ready[grant_ch] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_d     = rr_q;
        count_d  = count_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rr_d     = grant_ch + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (fifo_push && !fifo_pop) begin
            count_d = count_q + 1'b1;
        end else if (fifo_pop && !fifo_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        head_valid_d = !fifo_empty;
        head_d       = fifo_empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rr_q         <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rr_q         <= rr_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= {grant_ch, res_slice[grant_ch]};
        end
    end

`ifdef PIO_BRIDGE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    logic [TMR_W-1:0] tmr_q;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= ST_RESYNC;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            lat_tog_q    <= 1'b0;
            lat_ch_q     <= '0;
            cp_valid_q   <= '0;
            cp_payload_q <= '0;
`ifdef PIO_BRIDGE_TIMEOUT_EN
            tmr_q        <= '0;
`endif
        end else begin
            case (state_q)
                ST_RESYNC: begin
                    ack_q   <= cmd_tog;
                    state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (cmd_new) begin
                        lat_tog_q <= cmd_tog;
                        lat_ch_q  <= cmd_ch;
                        if (cmd_op) begin
                            // A pop on empty re-sets err even with clr_err.
                            if (fifo_empty) begin
                                err_q <= 1'b1;
                            end else if (cmd_clr) begin
                                err_q <= 1'b0;
                            end
                            state_q <= ST_ACK;
                        end else begin
                            if (cmd_clr) begin
                                err_q <= 1'b0;
                            end
                            cp_valid_q   <= cmd_onehot;
                            cp_payload_q <= cmd_pay;
`ifdef PIO_BRIDGE_TIMEOUT_EN
                            tmr_q        <= TMR_LOAD;
`endif
                            state_q      <= ST_DISPATCH;
                        end
                    end
                end
                ST_DISPATCH: begin
                    if (cp_ready[lat_ch_q]) begin
                        cp_valid_q <= '0;
                        state_q    <= ST_ACK;
                    end
`ifdef PIO_BRIDGE_TIMEOUT_EN
                    else if (tmr_q == '0) begin
                        cp_valid_q <= '0;
                        err_q      <= 1'b1;
                        state_q    <= ST_ACK;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
`endif
                end
                ST_ACK: begin
                    ack_q   <= lat_tog_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_RESYNC;
            endcase
        end
    end

    assign cp_valid   = cp_valid_q;
    assign cp_payload = cp_payload_q;
    assign hps_status = {ack_q, head_valid_q, err_q, head_q};

endmodule

// File: doc/pio_mailbox_bridge.md
# pio_mailbox_bridge

Parametrised command/result mailbox between the HPS PIO pair and N coprocessor channels. It sits in the FPGA fabric between the soc_system PIO exports and the coprocessor cores. It replaces direct 32-bit PIO wiring with:
- a toggle-handshaked command path to any channel,
- a round-robin-arbitrated result FIFO that the HPS drains one word per command.

## Interface
Parameters:
- WORD_W, 32: PIO word width; PAY_W = WORD_W-3-CH_W (27 at defaults).
- CH_W, 2: channel-select bits; N_CH = 2**CH_W.
- FIFO_DEPTH, 8: result FIFO entries, power of two ≥ 2.
- TIMEOUT_CYC, 1024: dispatch watchdog limit (used only with the macro).

Ports:
- clk_clk, input, 1: single clock; everything is synchronous to its rising edge.
- reset_reset, input, 1: synchronous, active-high reset.
- hps_cmd, input, WORD_W: connects to the data_out PIO export. Fields:
  - [W-1] req toggle
  - [W-2] op (0 = dispatch, 1 = pop)
  - [W-3] clr_err
  - [W-4 -: CH_W] channel
  - [PAY_W-1:0] payload
- hps_status, output, WORD_W: connects to the data_in PIO export. Fields:
  - [W-1] ack toggle
  - [W-2] head_valid
  - [W-3] err
  - [W-4 -: CH_W] head channel
  - [PAY_W-1:0] head payload
- cp_valid, output, N_CH: one-hot command valid.
- cp_payload, output, PAY_W: command payload, shared by all channels.
- cp_ready, input, N_CH: per-channel command ready.
- res_valid, input, N_CH: per-channel result valid.
- res_data, input, N_CH*PAY_W: result payloads; channel k occupies [k*PAY_W +: PAY_W].
- res_ready, output, N_CH: per-channel result accept.

## Operation
- hps_cmd is registered every cycle into cmd_q. All decisions use cmd_q.
- FSM states: RESYNC, IDLE, DISPATCH, ACK.
- RESYNC (first cycle after reset): ack ← cmd_q[W-1]; go to IDLE. A stale toggle therefore never fires a command.
- IDLE: when cmd_q[W-1] ≠ ack, latch the command. If clr_err=1, clear err first; an error from the same command then sets it again.
  - op=1 (pop): if FIFO is non-empty, pop the head; if empty, set err and leave the FIFO unchanged. Go to ACK.
  - op=0 (dispatch): drive cp_payload = latched payload and cp_valid[channel]=1. Go to DISPATCH.
- DISPATCH: hold cp_valid and cp_payload stable until cp_ready[channel]=1. On the transfer cycle, go to ACK.
- ACK: ack ← latched toggle; go to IDLE. Exactly one command is processed per toggle edge.
- Result path runs in parallel with the FSM:
  - Round-robin arbiter over res_valid; the pointer advances past the granted channel.
  - res_ready[g]=1 only for the granted channel g, and only when FIFO count < FIFO_DEPTH.
  - At most one push per cycle. The pushed entry is {channel g, res_data slice g}.
- FIFO is show-ahead: hps_status always shows the head. head_valid = (count ≠ 0). When empty, head channel and payload read 0.
- Count is clog2(FIFO_DEPTH+1) bits wide. Read/write pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- Simultaneous push and pop: both happen and count is unchanged. Full status comes from the registered count, so a pop does not admit a push into a full FIFO in the same cycle.
- err is sticky until a command arrives with clr_err=1.

## Timing
- Reset values: hps_status = 0; cp_valid = 0; cp_payload = 0; res_ready = 0; FIFO empty; arbiter pointer = 0; err = 0; state = RESYNC.
- Reset asserted mid-operation: abort immediately, drop cp_valid the next cycle, discard FIFO contents.
- Pop latency: toggle on hps_cmd at edge N → cmd_q at N+1 → pop at N+2 → ack and new head visible after edge N+3.
- Dispatch latency: cp_valid asserts after edge N+2. Ack is visible 1 cycle after the cp_ready transfer cycle.
- Result path: a res_valid/res_ready transfer at edge M appears at the head after edge M+1 (when the FIFO was empty).
- hps_status is fully registered; no combinational path from any input.

## Configuration
- PIO_BRIDGE_TIMEOUT_EN defined:
  - A cycle counter runs in DISPATCH.
  - If TIMEOUT_CYC cycles pass without cp_ready, deassert cp_valid, set err, and go to ACK. The command is dropped.
- Not defined:
  - No counter is built.
  - DISPATCH waits indefinitely.

## Test plan
- Reset release with hps_cmd[31]=1: no dispatch; hps_status[31]=1 after RESYNC.
- Dispatch to channel 2 with payload 0x1234567, cp_ready[2] held low 5 cycles: cp_valid=4'b0100 and payload stay stable throughout; ack flips 1 cycle after ready.
- Channels 0, 1 and 3 all assert res_valid with payloads 0xA, 0xB and 0xD: FIFO receives ch0, ch1, ch3 in that order. Three pops return 0xA, 0xB, 0xD; a fourth pop sets err=1 and head_valid=0.
- Fill with 8 results, hold a 9th res_valid: res_ready=0. After one pop the 9th is accepted one cycle later and count returns to 8.
- With the macro defined and TIMEOUT_CYC=16, cp_ready never asserted: cp_valid drops after 16 cycles, err=1, ack flips. The next command with clr_err=1 clears err.
